// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and the arbiter state encoding.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      SEND,
      WAIT_RELEASE
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of mask at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; found=0 when mask is empty.
module rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] mask,
   input  logic [IW-1:0]      ptr,
   output logic               found,
   output logic [IW-1:0]      idx
);

   // Scan from the farthest candidate back to ptr so the nearest hit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (mask[(int'(ptr) + k) % NUM_REQ]) begin
            found = 1'b1;
            idx   = IW'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers, round-robin with packet lock.
// Latency: req_valid -> req_ready 1 clk, -> tx_start 2 clk (when uart idle).
// Backpressure: one byte in flight; req_ready pulses only when the uart can take the next frame.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = UART_DATA_W,
   parameter int LOCK_TIMEOUT = 4096
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [DATA_W-1:0]          tx_data,
   output logic                       tx_start,
   input  logic                       tx_busy,
   input  logic                       tx_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       lock_active
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(LOCK_TIMEOUT + 1);

   arb_state_t          state;
   logic [IW-1:0]       rr_ptr;
   logic [CW-1:0]       idle_cnt;
   logic                last_q;
   logic [NUM_REQ-1:0]  pick_mask;
   logic                pick_found;
   logic [IW-1:0]       pick_idx;
   logic [IW-1:0]       next_ptr;

   // While locked only the owner may be picked; the picker then ignores rr_ptr.
   always_comb begin
      pick_mask = req_valid;
      if (lock_active) begin
         pick_mask = req_valid & (NUM_REQ'(1) << grant_id);
      end
   end

   assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .mask  (pick_mask),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         idle_cnt    <= '0;
         last_q      <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         req_ready   <= '0;
         grant_id    <= '0;
         lock_active <= 1'b0;
      end else begin
         req_ready <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id    <= pick_idx;
                  req_ready   <= NUM_REQ'(1) << pick_idx;
                  lock_active <= 1'b1;
                  idle_cnt    <= '0;
                  state       <= LOAD;
               end else if (lock_active) begin
                  if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                     lock_active <= 1'b0;
                     rr_ptr      <= next_ptr;
                     idle_cnt    <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + CW'(1);
                  end
               end
            end
            LOAD: begin
               // Capture only on the ready cycle: the producer may move on afterwards.
               if (req_ready != '0) begin
                  tx_data <= req_data[int'(grant_id)*DATA_W +: DATA_W];
                  last_q  <= req_last[grant_id];
               end
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (tx_busy) begin
                  tx_start <= 1'b0;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  state <= WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               if (last_q) begin
                  lock_active <= 1'b0;
                  rr_ptr      <= next_ptr;
                  state       <= IDLE;
               end else if (req_valid[grant_id]) begin
                  req_ready <= NUM_REQ'(1) << grant_id;
                  idle_cnt  <= '0;
                  state     <= LOAD;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_done_in_send: assert property (@(posedge clk) disable iff (!rst_n) tx_done |-> state == SEND);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx, queued requesters, order/latency/timeout/reset checks.
module tb_uart_tx_arbiter;

   localparam int N           = 4;
   localparam int DW          = 8;
   localparam int TO          = 16;
   localparam int FRAME_TICKS = 10;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic [DW-1:0]   tx_data;
   logic            tx_start;
   logic            tx_busy;
   logic            tx_done;
   logic [1:0]      grant_id;
   logic            lock_active;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (N),
      .DATA_W       (DW),
      .LOCK_TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .lock_active (lock_active)
   );

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] dat;
   } obs_t;

   typedef struct {
      logic [3:0] mask;
      int         n;
      int         ord [4];
   } tv_t;

   int         vec = 0;
   int         errs = 0;
   logic [8:0] rq [N][$];
   logic [8:0] refq [N][$];
   obs_t       obs [$];
   obs_t       expq [$];
   int         baud_div = 1;
   int         tick_ph = 0;
   int         bcnt = 0;
   bit         tick;
   logic [7:0] cur_data = '0;
   logic       s_start;
   logic [N-1:0] s_rdy, s_rdy_prev;
   logic [1:0] s_grant;
   logic [7:0] s_data;
   int         proto_err = 0;
   int         stab_err = 0;
   int         ptr_m = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push(input int id, input logic [7:0] d, input logic l);
      rq[id].push_back({l, d});
   endtask

   task automatic expect_byte(input int id, input logic [7:0] d);
      obs_t o;
      o.id  = 2'(id);
      o.dat = d;
      expq.push_back(o);
   endtask

   function automatic bit rq_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input string name, input int budget);
      int quiet = 0;
      int n = 0;
      while (quiet < 3 && n < budget) begin
         @(negedge clk);
         n++;
         if (rq_empty() && !tx_busy && !lock_active && !tx_start && req_valid == '0) quiet++;
         else quiet = 0;
      end
      chk({name, "_idle_reached"}, quiet >= 3, 1);
   endtask

   task automatic compare_stream(input string name);
      int m;
      chk({name, "_count"}, obs.size(), expq.size());
      m = (obs.size() < expq.size()) ? obs.size() : expq.size();
      for (int i = 0; i < m; i++) begin
         chk($sformatf("%s_id%0d", name, i), obs[i].id, expq[i].id);
         chk($sformatf("%s_dat%0d", name, i), obs[i].dat, expq[i].dat);
      end
      chk({name, "_protocol"}, proto_err, 0);
      chk({name, "_data_stable"}, stab_err, 0);
      obs.delete();
      expq.delete();
      proto_err = 0;
      stab_err  = 0;
   endtask

   // uart_tx model and requester drivers: sample on negedge, drive just after posedge
   initial begin
      logic [8:0] hd;
      tx_busy = 1'b0; tx_done = 1'b0;
      req_valid = '0; req_data = '0; req_last = '0;
      s_start = 1'b0; s_rdy = '0; s_rdy_prev = '0; s_grant = '0; s_data = '0;
      forever begin
         @(negedge clk);
         s_rdy_prev = s_rdy;
         s_rdy      = req_ready;
         s_start    = tx_start;
         s_grant    = grant_id;
         s_data     = tx_data;
         if (rst_n) begin
            if ((s_rdy & ~req_valid) != '0 || $countones(s_rdy) > 1 || (s_rdy & s_rdy_prev) != '0)
               proto_err++;
            if (tx_busy && tx_data != cur_data) stab_err++;
         end
         @(posedge clk);
         #1;
         if (!rst_n) begin
            bcnt    = 0;
            tick_ph = 0;
         end else begin
            tick    = (tick_ph == 0);
            tick_ph = (tick_ph + 1) % baud_div;
            if (bcnt > 0) begin
               if (tick) bcnt--;
            end else if (tick && s_start) begin
               bcnt     = FRAME_TICKS;
               cur_data = s_data;
               obs.push_back({s_grant, s_data});
            end
            for (int i = 0; i < N; i++)
               if (s_rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         end
         tx_busy = (bcnt > 0);
         tx_done = (bcnt == 1);
         for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
               hd = rq[i][0];
               req_valid[i]          = 1'b1;
               req_data[i*DW +: DW]  = hd[7:0];
               req_last[i]           = hd[8];
            end else begin
               req_valid[i]          = 1'b0;
               req_data[i*DW +: DW]  = '0;
               req_last[i]           = 1'b0;
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tv_t tbl [7];
      int  k, hv, vi, ri, si;
      logic [8:0] b;
      int  sel;

      tbl[0].mask = 4'b0101; tbl[0].n = 2; tbl[0].ord = '{2, 0, 0, 0};
      tbl[1].mask = 4'b1111; tbl[1].n = 4; tbl[1].ord = '{1, 2, 3, 0};
      tbl[2].mask = 4'b1001; tbl[2].n = 2; tbl[2].ord = '{3, 0, 0, 0};
      tbl[3].mask = 4'b0010; tbl[3].n = 1; tbl[3].ord = '{1, 0, 0, 0};
      tbl[4].mask = 4'b0011; tbl[4].n = 2; tbl[4].ord = '{0, 1, 0, 0};
      tbl[5].mask = 4'b1100; tbl[5].n = 2; tbl[5].ord = '{2, 3, 0, 0};
      tbl[6].mask = 4'b1010; tbl[6].n = 2; tbl[6].ord = '{1, 3, 0, 0};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_lock_active", lock_active, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // single byte: ready 1 clk after valid, tx_start 2 clk after valid
      push(0, 8'hA5, 1'b1);
      expect_byte(0, 8'hA5);
      vi = -1; ri = -1; si = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (vi < 0 && req_valid[0]) vi = c;
         if (ri < 0 && req_ready[0]) ri = c;
         if (si < 0 && tx_start) si = c;
      end
      chk("lat_ready", ri - vi, 1);
      chk("lat_start", si - vi, 2);
      wait_idle("lat", 500);
      compare_stream("lat");

      // round-robin order from a known pointer (starts at 1 after req0 served)
      for (int t = 0; t < 7; t++) begin
         for (int i = 0; i < N; i++)
            if (tbl[t].mask[i]) push(i, 8'(8'h80 + t * 16 + i), 1'b1);
         for (int j = 0; j < tbl[t].n; j++)
            expect_byte(tbl[t].ord[j], 8'(8'h80 + t * 16 + tbl[t].ord[j]));
         wait_idle($sformatf("tbl%0d", t), 2000);
         compare_stream($sformatf("tbl%0d", t));
      end

      // pointer at 0: req0 twice and req2 once -> 0,2,0; pointer ends at 1
      push(0, 8'h01, 1'b1); push(2, 8'h02, 1'b1); push(0, 8'h03, 1'b1);
      expect_byte(0, 8'h01); expect_byte(2, 8'h02); expect_byte(0, 8'h03);
      wait_idle("rr020", 2000);
      compare_stream("rr020");
      push(0, 8'h04, 1'b1); push(1, 8'h05, 1'b1);
      expect_byte(1, 8'h05); expect_byte(0, 8'h04);
      wait_idle("rrptr1", 2000);
      compare_stream("rrptr1");

      // 3-byte packet from req1 keeps the uart while req3 waits
      push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b0); push(1, 8'hB3, 1'b1);
      k = 0;
      while (!lock_active && k < 50) begin @(negedge clk); k++; end
      chk("pkt_lock_seen", lock_active, 1);
      push(3, 8'hB4, 1'b1);
      expect_byte(1, 8'hB1); expect_byte(1, 8'hB2); expect_byte(1, 8'hB3); expect_byte(3, 8'hB4);
      wait_idle("pkt", 3000);
      compare_stream("pkt");

      // lock timeout: req1 goes silent mid-packet, req3 must get the uart after TO idle clocks
      push(1, 8'h51, 1'b0);
      k = 0;
      while (!lock_active && k < 50) begin @(negedge clk); k++; end
      chk("to_lock_seen", lock_active, 1);
      push(3, 8'h53, 1'b1);
      k = 0;
      while (!tx_busy && k < 50) begin @(negedge clk); k++; end
      chk("to_busy_seen", tx_busy, 1);
      k = 0;
      while (tx_busy && k < 100) begin @(negedge clk); k++; end
      chk("to_busy_fall", tx_busy, 0);
      // busy-fall sample, WAIT_RELEASE, then TO locked idle cycles
      k = 0;
      while (lock_active && k < 200) begin k++; @(negedge clk); end
      chk("to_lock_cycles", k, TO + 2);
      @(negedge clk);
      chk("to_next_grant_ready", req_ready, 4'b1000);
      push(1, 8'h52, 1'b1);
      expect_byte(1, 8'h51); expect_byte(3, 8'h53); expect_byte(1, 8'h52);
      wait_idle("to", 3000);
      compare_stream("to");

      // slow baud: tx_start held until busy, dropped one clock later
      baud_div = 16;
      push(2, 8'hC3, 1'b1);
      expect_byte(2, 8'hC3);
      k = 0;
      while (!tx_start && k < 50) begin @(negedge clk); k++; end
      chk("slow_start_seen", tx_start, 1);
      hv = 0; k = 0;
      while (!tx_busy && k < 100) begin
         if (!tx_start) hv++;
         @(negedge clk);
         k++;
      end
      chk("slow_start_hold", hv, 0);
      chk("slow_start_at_busy", tx_start, 1);
      @(negedge clk);
      chk("slow_start_drop", tx_start, 0);
      wait_idle("slow", 3000);
      compare_stream("slow");
      baud_div = 1;

      // reset mid-frame: outputs clear at once, pending requests restart from pointer 0
      push(2, 8'h22, 1'b1);
      k = 0;
      while (!tx_busy && k < 50) begin @(negedge clk); k++; end
      repeat (3) @(negedge clk);
      push(1, 8'h11, 1'b1); push(3, 8'h33, 1'b1);
      repeat (2) @(negedge clk);
      chk("pre_rst_grant", grant_id, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_tx_start", tx_start, 0);
      chk("arst_tx_data", tx_data, 0);
      chk("arst_req_ready", req_ready, 0);
      chk("arst_grant_id", grant_id, 0);
      chk("arst_lock_active", lock_active, 0);
      obs.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      proto_err = 0;
      stab_err  = 0;
      expect_byte(1, 8'h11); expect_byte(3, 8'h33);
      wait_idle("rst", 2000);
      compare_stream("rst");

      // randomized packets against a queue-level round-robin model
      ptr_m = 0;
      for (int it = 0; it < 6; it++) begin
         baud_div = $urandom_range(1, 3);
         for (int i = 0; i < N; i++) begin
            int npk;
            npk = $urandom_range(0, 2);
            for (int p = 0; p < npk; p++) begin
               int len;
               len = $urandom_range(1, 3);
               for (int j = 0; j < len; j++) begin
                  b = {(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)};
                  push(i, b[7:0], b[8]);
                  refq[i].push_back(b);
               end
            end
         end
         forever begin
            sel = -1;
            for (int s = 0; s < N; s++)
               if (sel < 0 && refq[(ptr_m + s) % N].size() > 0) sel = (ptr_m + s) % N;
            if (sel < 0) break;
            do begin
               b = refq[sel].pop_front();
               expect_byte(sel, b[7:0]);
            end while (!b[8]);
            ptr_m = (sel + 1) % N;
         end
         wait_idle($sformatf("rnd%0d", it), 8000);
         compare_stream($sformatf("rnd%0d", it));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
